bird_ctrl: RTL and testbench

BIRD_CTRL -- requirements
Module: bird_ctrl

---
 rtl/bird_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bird_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bird_ctrl.sv
// Bird sprite controller: frame-rate vertical physics, flap/collision handling
// and IDLE/FLY/DEAD sequencing, producing sprite origin and control for the sprite source.
//
// state  | meaning
// IDLE   | parked at Y_START, waiting for a flap to launch
// FLY    | gravity and flaps applied each frame, collisions kill
// DEAD   | falls to the floor, a flap there restarts to IDLE
module bird_ctrl #(
    parameter int          X_POS      = 100,
    parameter int          Y_START    = 224,
    parameter int          Y_CEIL     = 0,
    parameter int          Y_FLOOR    = 448,
    parameter int          GRAVITY    = 1,
    parameter int          FLAP_VEL   = -8,
    parameter int          V_MAX      = 8,
    parameter logic [1:0]  BIRD_COLOR = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        flap,
    input  logic        collide,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [4:0]  ctrl,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [10:0]        X_POS11   = 11'(X_POS);
    localparam logic [10:0]        Y_START11 = 11'(Y_START);
    localparam logic [10:0]        Y_CEIL11  = 11'(Y_CEIL);
    localparam logic [10:0]        Y_FLOOR11 = 11'(Y_FLOOR);
    localparam logic signed [11:0] Y_CEIL12  = 12'(Y_CEIL);
    localparam logic signed [11:0] Y_FLOOR12 = 12'(Y_FLOOR);
    localparam logic signed [7:0]  GRAV8     = 8'(GRAVITY);
    localparam logic signed [7:0]  FLAP8     = 8'(FLAP_VEL);
    localparam logic signed [7:0]  VMAX8     = 8'(V_MAX);
    localparam logic [4:0]         CTRL_IDLE = {BIRD_COLOR, 1'b0, 2'b00};
    localparam logic [4:0]         CTRL_FLY  = {BIRD_COLOR, 1'b1, 2'b00};
    localparam logic [4:0]         CTRL_DEAD = {2'b00, 1'b0, 2'b10};

    state_t             state_q, state_d;
    logic [10:0]        x0_q, x0_d;
    logic [10:0]        y0_q, y0_d;
    logic signed [7:0]  vy_q, vy_d;
    logic               flap_pend_q, flap_pend_d;
    logic               flap_prev_q, flap_prev_d;
    logic [10:0]        x_prev_q, x_prev_d;
    logic [4:0]         ctrl_q, ctrl_d;
    logic               game_over_q, game_over_d;

    logic               frame_tick;
    logic               flap_edge;
    logic               flap_now;
    logic signed [11:0] y_sum;
    logic signed [7:0]  vy_inc;
    logic signed [7:0]  vy_grav;

    always_comb begin
        frame_tick  = (x_prev_q == 11'd0) && (x == 11'd1) && (y == 11'd0);
        flap_edge   = flap & ~flap_prev_q;
        // an edge landing on the tick cycle is taken by that tick, never carried over
        flap_now    = flap_pend_q | flap_edge;
        flap_pend_d = frame_tick ? 1'b0 : flap_now;
        flap_prev_d = flap;
        x_prev_d    = x;
        x0_d        = X_POS11;

        y_sum   = $signed({1'b0, y0_q}) + $signed({{4{vy_q[7]}}, vy_q});
        vy_inc  = vy_q + GRAV8;
        vy_grav = (vy_inc > VMAX8) ? VMAX8 : vy_inc;

        state_d = state_q;
        y0_d    = y0_q;
        vy_d    = vy_q;

        case (state_q)
            S_IDLE: begin
                y0_d = Y_START11;
                vy_d = 8'sd0;
                if (frame_tick && flap_now) begin
                    state_d = S_FLY;
                    vy_d    = FLAP8;
                end
            end
            S_FLY: begin
                if (collide) begin
                    state_d = S_DEAD;
                    vy_d    = 8'sd0;
                end else if (frame_tick) begin
                    if (y_sum < Y_CEIL12) begin
                        y0_d = Y_CEIL11;
                        vy_d = flap_now ? FLAP8 : 8'sd0;
                    end else if (y_sum >= Y_FLOOR12) begin
                        y0_d    = Y_FLOOR11;
                        vy_d    = 8'sd0;
                        state_d = S_DEAD;
                    end else begin
                        y0_d = y_sum[10:0];
                        vy_d = flap_now ? FLAP8 : vy_grav;
                    end
                end
            end
            S_DEAD: begin
                if (frame_tick) begin
                    if (y0_q < Y_FLOOR11) begin
                        if (y_sum >= Y_FLOOR12) begin
                            y0_d = Y_FLOOR11;
                            vy_d = 8'sd0;
                        end else begin
                            y0_d = y_sum[10:0];
                            vy_d = vy_grav;
                        end
                    end else if (flap_now) begin
                        state_d = S_IDLE;
                        y0_d    = Y_START11;
                        vy_d    = 8'sd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                y0_d    = Y_START11;
                vy_d    = 8'sd0;
            end
        endcase

        case (state_d)
            S_FLY:   ctrl_d = CTRL_FLY;
            S_DEAD:  ctrl_d = CTRL_DEAD;
            default: ctrl_d = CTRL_IDLE;
        endcase
        game_over_d = (state_d == S_DEAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= X_POS11;
            y0_q        <= Y_START11;
            vy_q        <= 8'sd0;
            flap_pend_q <= 1'b0;
            flap_prev_q <= 1'b0;
            x_prev_q    <= 11'd0;
            ctrl_q      <= CTRL_IDLE;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            vy_q        <= vy_d;
            flap_pend_q <= flap_pend_d;
            flap_prev_q <= flap_prev_d;
            x_prev_q    <= x_prev_d;
            ctrl_q      <= ctrl_d;
            game_over_q <= game_over_d;
        end
    end

    assign x0        = x0_q;
    assign y0        = y0_q;
    assign ctrl      = ctrl_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl: launch, gravity saturation, floor, ceiling,
// collision, restart and asynchronous reset, with hand-computed trajectories.
module tb_bird_ctrl;

    logic        clk;
    logic        reset;
    logic [10:0] x;
    logic [10:0] y;
    logic        flap;
    logic        collide;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [4:0]  ctrl;
    logic        game_over;

    int n_total = 0;
    int n_bad   = 0;

    bird_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .flap      (flap),
        .collide   (collide),
        .x0        (x0),
        .y0        (y0),
        .ctrl      (ctrl),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // optional flap edge one cycle ahead, then one frame tick
    task automatic frame(input bit f);
        if (f) begin
            flap = 1'b1;
            step();
            flap = 1'b0;
        end
        x = 11'd0; y = 11'd0;
        step();
        x = 11'd1;
        step();
        x = 11'd5; y = 11'd3;
    endtask

    // flap edge arrives in the very cycle of the tick
    task automatic frame_co();
        x = 11'd0; y = 11'd0;
        step();
        x = 11'd1; flap = 1'b1;
        step();
        flap = 1'b0;
        x = 11'd5; y = 11'd3;
    endtask

    int exp_rise [18] = '{216, 209, 203, 198, 194, 191, 189, 188, 188,
                          189, 191, 194, 198, 203, 209, 216, 224, 232};

    initial begin
        reset = 1'b1; flap = 1'b0; collide = 1'b0; x = 11'd5; y = 11'd3;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_x0", 32'(x0), 32'd100);
        check("rst_y0", 32'(y0), 32'd224);
        check("rst_ctrl", 32'(ctrl), 32'b10000);
        check("rst_go", 32'(game_over), 32'd0);

        collide = 1'b1; step(); collide = 1'b0; step();
        check("idle_collide_go", 32'(game_over), 32'd0);
        frame(1'b0);
        check("idle_noflap_ctrl", 32'(ctrl), 32'b10000);

        // launch and free flight to the floor
        frame(1'b1);
        check("launch_ctrl", 32'(ctrl), 32'b10100);
        check("launch_y0", 32'(y0), 32'd224);
        for (int k = 0; k < 18; k++) begin
            frame(1'b0);
            check($sformatf("rise_t%0d", k + 1), 32'(y0), 32'(exp_rise[k]));
        end
        for (int k = 19; k <= 44; k++) begin
            frame(1'b0);
            check($sformatf("fall_t%0d", k), 32'(y0), 32'(232 + 8 * (k - 18)));
        end
        check("fall_t44_go", 32'(game_over), 32'd0);
        frame(1'b0);
        check("floor_y0", 32'(y0), 32'd448);
        check("floor_go", 32'(game_over), 32'd1);
        check("floor_ctrl", 32'(ctrl), 32'b00010);
        frame(1'b0);
        check("dead_floor_hold", 32'(y0), 32'd448);
        frame(1'b1);
        check("restart_y0", 32'(y0), 32'd224);
        check("restart_ctrl", 32'(ctrl), 32'b10000);
        check("restart_go", 32'(game_over), 32'd0);

        // collision mid-flight, then fall and restart
        frame(1'b1);
        for (int k = 0; k < 26; k++) frame(1'b0);
        check("pre_collide_y0", 32'(y0), 32'd296);
        collide = 1'b1; step(); collide = 1'b0;
        check("collide_go", 32'(game_over), 32'd1);
        check("collide_y0", 32'(y0), 32'd296);
        check("collide_ctrl", 32'(ctrl), 32'b00010);
        frame(1'b0);
        check("dead_t1", 32'(y0), 32'd296);
        frame(1'b0);
        check("dead_t2", 32'(y0), 32'd297);
        frame(1'b1);
        check("dead_flap_ignored_y0", 32'(y0), 32'd299);
        check("dead_flap_ignored_go", 32'(game_over), 32'd1);
        frame(1'b0);
        check("dead_t4", 32'(y0), 32'd302);
        for (int k = 0; k < 40 && y0 != 11'd448; k++) frame(1'b0);
        check("dead_fall_floor", 32'(y0), 32'd448);
        frame(1'b1);
        check("restart2_y0", 32'(y0), 32'd224);
        check("restart2_go", 32'(game_over), 32'd0);

        // collide wins over a coincident tick
        frame(1'b1);
        x = 11'd0; y = 11'd0;
        step();
        x = 11'd1; collide = 1'b1;
        step();
        collide = 1'b0; x = 11'd5; y = 11'd3;
        check("collide_tick_y0", 32'(y0), 32'd224);
        check("collide_tick_go", 32'(game_over), 32'd1);
        for (int k = 0; k < 60 && y0 != 11'd448; k++) frame(1'b0);
        check("collide_tick_floor", 32'(y0), 32'd448);
        frame(1'b1);
        check("restart3_ctrl", 32'(ctrl), 32'b10000);

        // flap edge on the tick cycle is consumed exactly once
        frame_co();
        check("co_ctrl", 32'(ctrl), 32'b10100);
        check("co_y0", 32'(y0), 32'd224);
        frame(1'b0);
        check("co_t1", 32'(y0), 32'd216);
        frame(1'b0);
        check("co_t2", 32'(y0), 32'd209);

        // climb to the ceiling
        for (int k = 3; k <= 7; k++) frame(1'b0);
        frame(1'b1);
        check("climb_start", 32'(y0), 32'd188);
        for (int k = 0; k < 23; k++) frame(1'b1);
        check("climb_y4", 32'(y0), 32'd4);
        frame(1'b0);
        check("ceil_y0", 32'(y0), 32'd0);
        frame(1'b0);
        check("ceil_vy0", 32'(y0), 32'd0);
        frame(1'b0);
        check("ceil_vy1", 32'(y0), 32'd1);
        frame(1'b0);
        check("ceil_t3", 32'(y0), 32'd3);

        // asynchronous reset mid-flight
        #3 reset = 1'b1;
        #1;
        check("async_rst_y0", 32'(y0), 32'd224);
        check("async_rst_ctrl", 32'(ctrl), 32'b10000);
        check("async_rst_go", 32'(game_over), 32'd0);
        check("async_rst_x0", 32'(x0), 32'd100);
        step();
        reset = 1'b0;
        frame(1'b0);
        check("post_rst_idle", 32'(ctrl), 32'b10000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
